// File: rtl/ext_int_sequencer_if.sv
// Level request / retire-acknowledge pair between the external interrupt
// controller (master) and the core-side entry sequencer (slave).
interface ext_int_sequencer_if;
  logic ext_int_trigger;
  logic ext_int_handled;

  modport master (
    output ext_int_trigger,
    input  ext_int_handled
  );

  modport slave (
    input  ext_int_trigger,
    output ext_int_handled
  );
endinterface

// File: rtl/ext_int_sequencer.sv
// Core-side external interrupt entry sequencer.
// It takes the interrupt only at an instruction-retire boundary while mie=1.
// On entry it saves mepc, clears mie, and redirects fetch to the trap vector.
// The mret path restores mie from mpie.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | no request being serviced; mret / mie writes applied here
// PENDING | request seen with mie=1, waiting for the next retire
// ENTER   | one-cycle fetch redirect + handled pulse, core is flushing
module ext_int_sequencer #(
  parameter int XLEN = 32
) (
  input  logic                clk,
  input  logic                rst,
  ext_int_sequencer_if.slave  irq,
  input  logic                mie_wr,
  input  logic                mie_wdata,
  output logic                mie,
  output logic                mpie,
  input  logic [XLEN-1:0]     mtvec,
  input  logic                retire,
  input  logic [XLEN-1:0]     retire_next_pc,
  input  logic                mret,
  output logic                trap_redirect,
  output logic [XLEN-1:0]     trap_pc,
  output logic [XLEN-1:0]     mepc
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PENDING = 2'd1,
    ENTER   = 2'd2
  } state_t;

  state_t state;

  // The vector is word aligned, so the low two bits of mtvec are never used.
  logic unused_mtvec_lsbs;
  assign unused_mtvec_lsbs = ^mtvec[1:0];

  // The handled pulse and the redirect come from the same register.
  assign irq.ext_int_handled = trap_redirect;

  // The sequencer FSM updates the CSR state and the registered outputs together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      mie           <= 1'b0;
      mpie          <= 1'b0;
      mepc          <= '0;
      trap_pc       <= '0;
      trap_redirect <= 1'b0;
    end else begin
      trap_redirect <= 1'b0;
      case (state)
        IDLE: begin
          // mret first, then a software write to mie takes priority over it.
          if (retire && mret) begin
            mie  <= mpie;
            mpie <= 1'b1;
          end
          if (mie_wr) begin
            mie <= mie_wdata;
          end
          if (irq.ext_int_trigger && mie) begin
            state <= PENDING;
          end
        end

        PENDING: begin
          if (retire) begin
            // A retiring mret completes before the entry, so the enable saved
            // into mpie is the one that mret would have restored.
            state         <= ENTER;
            mepc          <= retire_next_pc;
            trap_pc       <= {mtvec[XLEN-1:2], 2'b00};
            mie           <= 1'b0;
            mpie          <= mret ? mpie : mie;
            trap_redirect <= 1'b1;
          end else begin
            if (mie_wr) begin
              mie <= mie_wdata;
            end
            if (!irq.ext_int_trigger || (mie_wr && !mie_wdata)) begin
              state <= IDLE;
            end
          end
        end

        ENTER: begin
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ext_int_sequencer.sv
// Scoreboard bench for ext_int_sequencer. Each interrupt entry that the
// stimulus provokes queues its expected trap_pc/mepc/mie/mpie. The negedge
// monitor pops the queue on every handled pulse. Any pulse with nothing
// queued counts as an error.
module tb_ext_int_sequencer;

  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic            mie_wr;
  logic            mie_wdata;
  logic            mie;
  logic            mpie;
  logic [XLEN-1:0] mtvec;
  logic            retire;
  logic [XLEN-1:0] retire_next_pc;
  logic            mret;
  logic            trap_redirect;
  logic [XLEN-1:0] trap_pc;
  logic [XLEN-1:0] mepc;

  ext_int_sequencer_if irq_if ();

  ext_int_sequencer #(.XLEN(XLEN)) dut (
    .clk            (clk),
    .rst            (rst),
    .irq            (irq_if.slave),
    .mie_wr         (mie_wr),
    .mie_wdata      (mie_wdata),
    .mie            (mie),
    .mpie           (mpie),
    .mtvec          (mtvec),
    .retire         (retire),
    .retire_next_pc (retire_next_pc),
    .mret           (mret),
    .trap_redirect  (trap_redirect),
    .trap_pc        (trap_pc),
    .mepc           (mepc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] epc;
    logic            ie;
    logic            pie;
  } exp_t;

  exp_t sb[$];

  int n_chk = 0;
  int n_err = 0;
  int n_pulse = 0;
  int cyc = 0;
  int last_pulse = 0;
  int gap = 0;
  logic prev_h = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic expect_entry(input logic [XLEN-1:0] vec, input logic [XLEN-1:0] npc,
                              input logic pie);
    exp_t e;
    e.pc  = {vec[XLEN-1:2], 2'b00};
    e.epc = npc;
    e.ie  = 1'b0;
    e.pie = pie;
    sb.push_back(e);
  endtask

  // The monitor samples the outputs on every negedge and checks each handled pulse.
  always @(negedge clk) begin
    exp_t e;
    cyc++;
    chk("redir_eq_handled", {31'd0, trap_redirect}, {31'd0, irq_if.ext_int_handled});
    if (irq_if.ext_int_handled) begin
      chk("pulse_width", {31'd0, prev_h}, 32'd0);
      chk("sb_nonempty", {31'd0, sb.size() != 0}, 32'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("entry_trap_pc", trap_pc, e.pc);
        chk("entry_mepc", mepc, e.epc);
        chk("entry_mie", {31'd0, mie}, {31'd0, e.ie});
        chk("entry_mpie", {31'd0, mpie}, {31'd0, e.pie});
      end
      gap = cyc - last_pulse;
      last_pulse = cyc;
      n_pulse++;
    end
    prev_h = irq_if.ext_int_handled;
  end

  task automatic write_mie(input logic v);
    mie_wr = 1'b1; mie_wdata = v;
    step();
    mie_wr = 1'b0; mie_wdata = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_mie"}, {31'd0, mie}, 32'd0);
    chk({tag, "_mpie"}, {31'd0, mpie}, 32'd0);
    chk({tag, "_mepc"}, mepc, 32'd0);
    chk({tag, "_trap_pc"}, trap_pc, 32'd0);
    chk({tag, "_redirect"}, {31'd0, trap_redirect}, 32'd0);
    chk({tag, "_handled"}, {31'd0, irq_if.ext_int_handled}, 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  int p0;

  initial begin
    rst = 1'b1; mie_wr = 1'b0; mie_wdata = 1'b0; mtvec = '0;
    retire = 1'b0; retire_next_pc = '0; mret = 1'b0;
    irq_if.ext_int_trigger = 1'b0;
    step();
    step();
    check_all_zero("reset");
    rst = 1'b0;

    // A basic entry that reaches the redirect two cycles after the trigger.
    write_mie(1'b1);
    chk("mie_written", {31'd0, mie}, 32'd1);
    irq_if.ext_int_trigger = 1'b1;
    step();
    retire = 1'b1; retire_next_pc = 32'h0000_0040; mtvec = 32'h0000_0103;
    expect_entry(mtvec, retire_next_pc, 1'b1);
    step();
    retire = 1'b0; irq_if.ext_int_trigger = 1'b0;
    step();
    chk("t1_hold_mepc", mepc, 32'h0000_0040);
    chk("t1_hold_trap_pc", trap_pc, 32'h0000_0100);
    chk("t1_mie", {31'd0, mie}, 32'd0);
    chk("t1_mpie", {31'd0, mpie}, 32'd1);
    chk("t1_pulses", n_pulse, 1);

    // No entry while mie=0, even with the trigger held and an instruction retiring every cycle.
    p0 = n_pulse;
    irq_if.ext_int_trigger = 1'b1;
    for (int i = 0; i < 20; i++) begin
      retire = 1'b1; retire_next_pc = 32'h1000 + 32'(i * 4);
      step();
    end
    retire = 1'b0; irq_if.ext_int_trigger = 1'b0;
    step();
    chk("t2_no_entry", n_pulse, p0);
    chk("t2_mepc_hold", mepc, 32'h0000_0040);

    // The trigger drops while PENDING, so there is no entry.
    write_mie(1'b1);
    irq_if.ext_int_trigger = 1'b1;
    step();
    step();
    irq_if.ext_int_trigger = 1'b0;
    step();
    retire = 1'b1; retire_next_pc = 32'h0000_0500;
    step();
    retire = 1'b0;
    step();
    chk("t3a_no_entry", n_pulse, p0);
    chk("t3a_mie", {31'd0, mie}, 32'd1);

    // Software clears mie while PENDING, so there is no entry.
    irq_if.ext_int_trigger = 1'b1;
    step();
    write_mie(1'b0);
    chk("t3b_mie", {31'd0, mie}, 32'd0);
    write_mie(1'b1);
    irq_if.ext_int_trigger = 1'b0;
    retire = 1'b1;
    step();
    retire = 1'b0;
    step();
    chk("t3b_no_entry", n_pulse, p0);

    // An entry, then mret, then a second entry with the trigger still high.
    irq_if.ext_int_trigger = 1'b1;
    step();
    retire = 1'b1; retire_next_pc = 32'h0000_0200; mtvec = 32'h0000_1000;
    expect_entry(mtvec, retire_next_pc, 1'b1);
    step();
    retire = 1'b0;
    step();
    retire = 1'b1; mret = 1'b1; retire_next_pc = 32'h0000_0204;
    step();
    retire = 1'b0; mret = 1'b0;
    chk("t4_mret_mie", {31'd0, mie}, 32'd1);
    chk("t4_mret_mpie", {31'd0, mpie}, 32'd1);
    chk("t4_mret_mepc", mepc, 32'h0000_0200);
    step();
    retire = 1'b1; retire_next_pc = 32'h0000_0300;
    expect_entry(mtvec, retire_next_pc, 1'b1);
    step();
    retire = 1'b0; irq_if.ext_int_trigger = 1'b0;
    step();
    chk("t4_gap_min", {31'd0, gap >= 3}, 32'd1);
    chk("t4_gap", gap, 4);

    // mret coincides with the entry while mpie=0, and a same-cycle mie write is dropped.
    do_reset();
    write_mie(1'b1);
    irq_if.ext_int_trigger = 1'b1;
    step();
    mtvec = 32'h0000_2002;
    retire = 1'b1; mret = 1'b1; retire_next_pc = 32'h0000_0080;
    mie_wr = 1'b1; mie_wdata = 1'b1;
    expect_entry(mtvec, retire_next_pc, 1'b0);
    step();
    retire = 1'b0; mret = 1'b0; mie_wr = 1'b0; mie_wdata = 1'b0;
    irq_if.ext_int_trigger = 1'b0;
    step();
    chk("t5_mepc", mepc, 32'h0000_0080);
    chk("t5_mie", {31'd0, mie}, 32'd0);
    chk("t5_mpie", {31'd0, mpie}, 32'd0);

    // A standalone mret, then an mret with an mie write in the same cycle.
    retire = 1'b1; mret = 1'b1;
    step();
    chk("t5_mret_mie", {31'd0, mie}, 32'd0);
    chk("t5_mret_mpie", {31'd0, mpie}, 32'd1);
    mie_wr = 1'b1; mie_wdata = 1'b0;
    step();
    retire = 1'b0; mret = 1'b0; mie_wr = 1'b0;
    chk("t5_wr_wins_mie", {31'd0, mie}, 32'd0);
    chk("t5_wr_mpie", {31'd0, mpie}, 32'd1);

    // A reset while PENDING aborts the entry.
    p0 = n_pulse;
    write_mie(1'b1);
    irq_if.ext_int_trigger = 1'b1;
    step();
    rst = 1'b1; retire = 1'b1; retire_next_pc = 32'h0000_0600;
    step();
    rst = 1'b0; retire = 1'b0; irq_if.ext_int_trigger = 1'b0;
    check_all_zero("rst_pend");
    step();
    check_all_zero("rst_pend2");
    chk("rst_pend_no_pulse", n_pulse, p0);

    // A reset during ENTER clears everything on the next cycle.
    write_mie(1'b1);
    irq_if.ext_int_trigger = 1'b1;
    step();
    mtvec = 32'h0000_3000;
    retire = 1'b1; retire_next_pc = 32'h0000_0700;
    expect_entry(mtvec, retire_next_pc, 1'b1);
    step();
    rst = 1'b1; retire = 1'b0; irq_if.ext_int_trigger = 1'b0;
    step();
    rst = 1'b0;
    check_all_zero("rst_enter");
    step();
    step();
    chk("rst_enter_pulses", n_pulse, p0 + 1);
    chk("sb_drained", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/ext_int_sequencer.md
Name: ext_int_sequencer

Overview:
- Core-side partner of the external interrupt controller.
- Consumes the controller's level interrupt request (ext_int_trigger) and decides when the core takes the interrupt: only at an instruction-retire boundary, and only while globally enabled.
- On entry it saves the return PC, clears the global enable, redirects fetch to the trap vector, and returns a one-cycle ext_int_handled pulse so the controller retires one pending source.
- Also implements the mret return path (mie/mpie restore).

Parameters:
XLEN, 32, width of PC, mtvec and mepc.

Ports:
clk  in  1  clock; all state updates on posedge.
rst  in  1  synchronous active-high reset.
ext_int_trigger  in  1  level interrupt request from the external interrupt controller.
ext_int_handled  out  1  one-cycle pulse to the controller on each interrupt entry.
mie_wr  in  1  software write strobe for the global interrupt enable.
mie_wdata  in  1  value written to mie when mie_wr=1.
mie  out  1  global interrupt enable.
mpie  out  1  previous enable, saved on entry.
mtvec  in  XLEN  trap vector base; bits [1:0] ignored.
retire  in  1  one instruction retires this cycle.
retire_next_pc  in  XLEN  PC of the next instruction to execute; valid when retire=1.
mret  in  1  the retiring instruction is mret; only meaningful when retire=1.
trap_redirect  out  1  one-cycle fetch redirect request.
trap_pc  out  XLEN  redirect target; valid while trap_redirect=1.
mepc  out  XLEN  saved return PC.

Behaviour:
- Reset (rst=1 at posedge): state=IDLE, mie=0, mpie=0, mepc=0, trap_pc=0, trap_redirect=0, ext_int_handled=0. Reset mid-PENDING or mid-ENTER aborts with no pulse on the following cycle.
- States: IDLE, PENDING, ENTER. trap_redirect and ext_int_handled are registered and equal (state==ENTER).
- IDLE:
  - ext_int_trigger=1 and mie=1 (current register value) -> PENDING next cycle.
  - Otherwise stay in IDLE.
- PENDING:
  - retire=1 -> ENTER next cycle. Same edge: mepc<=retire_next_pc, trap_pc<={mtvec[XLEN-1:2],2'b00}, mie<=0, mpie<=effective mie.
    - Effective mie = mpie if mret=1 (mret completes first), else mie.
    - When mret=1, mpie's own mret update (mpie<=1) is overridden by the entry value.
  - Else, ext_int_trigger=0, or (mie_wr=1 and mie_wdata=0) -> IDLE, no entry.
  - Else stay in PENDING.
  - retire has priority over a same-cycle mie_wr; the write is discarded and mie<=0.
- ENTER:
  - Lasts exactly one cycle. trap_redirect=1 and ext_int_handled=1 during it; then IDLE unconditionally.
  - retire, mret and mie_wr are ignored in ENTER (core is flushing).
- mret (retire=1 and mret=1) outside entry: mie<=mpie, mpie<=1. mepc unchanged.
- mie_wr outside PENDING-entry/ENTER: mie<=mie_wdata. Same cycle as mret: mie_wr wins for mie, mret still sets mpie<=1.
- Latency:
  - trigger&mie sampled at edge N -> PENDING after N.
  - First retire at edge M>N -> redirect/handled high in cycle M+1.
  - Minimum trigger-to-redirect: 2 cycles.
- No re-entry while mie=0. Back-to-back interrupts need mret (restoring mie=1) and a fresh PENDING pass. Minimum gap between handled pulses: 3 cycles after mret retires.
- trap_pc and mepc hold their values outside ENTER.

Test Plan:
- Reset then mie_wr=1/mie_wdata=1; raise trigger; retire=1 one cycle later with retire_next_pc=0x0000_0040, mtvec=0x0000_0103 -> next cycle trap_redirect=ext_int_handled=1 for exactly 1 cycle, trap_pc=0x0000_0100, mepc=0x40, mie=0, mpie=1.
- mie=0, trigger held high 20 cycles with retires every cycle -> no redirect, no handled pulse, state stays IDLE.
- Reach PENDING, drop trigger before any retire -> IDLE, no pulse. Repeat, writing mie_wdata=0 in PENDING -> IDLE, mie=0, no pulse.
- After entry (mie=0, mpie=1), retire with mret=1 -> mie=1, mpie=1. Trigger still high -> second entry; handled pulses separated by >=3 cycles.
- In PENDING, retire=1 with mret=1, mpie=0, retire_next_pc=0x80 -> entry occurs, mepc=0x80, mpie=0, mie=0.
- Assert rst while in PENDING and while in ENTER -> next cycle all outputs 0, no handled pulse.
